// File: rtl/custom_ext_pkg.sv
// Shared definitions for the custom-0 execute unit: funct3 encodings, FSM states, control payload.
package custom_ext_pkg;

    localparam logic [2:0] CX_XNOR      = 3'b000;
    localparam logic [2:0] CX_VADD      = 3'b001;
    localparam logic [2:0] CX_VSUB      = 3'b010;
    localparam logic [2:0] CX_VADDU_SAT = 3'b011;
    localparam logic [2:0] CX_BREV      = 3'b100;
    localparam logic [2:0] CX_MUL       = 3'b101;

    localparam logic [6:0] CX_FUNCT7_LEGAL = 7'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cx_state_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
    } cx_ctrl_t;

    // True when the captured op must complete with resp_err.
    function automatic logic cx_illegal(input cx_ctrl_t ctrl, input logic mul_en);
        return (ctrl.funct7 != CX_FUNCT7_LEGAL)
            || (ctrl.funct3 == 3'b110)
            || (ctrl.funct3 == 3'b111)
            || ((ctrl.funct3 == CX_MUL) && !mul_en);
    endfunction

endpackage

// File: rtl/custom_ext_iter_mul.sv
// Radix-2 shift-add multiplier producing the low XLEN bits of a*b, one partial product per cycle.
module custom_ext_iter_mul #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [CNT_W-1:0] cnt;

    // The start cycle already folds in bit 0, so busy covers the remaining XLEN-1 steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (clear) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (start) begin
            product <= b[0] ? a : '0;
            mcand   <= a << 1;
            mplier  <= b >> 1;
            cnt     <= CNT_W'(1);
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/custom_ext_seq_unit.sv
// Custom-0 sequential execute unit: lane SIMD add/sub/sat-add, XNOR, bit reverse, optional MUL.
// Define CUSTOM_EXT_MUL_EN to build the iterative multiplier for funct3 101.
module custom_ext_seq_unit
    import custom_ext_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);

    localparam int unsigned NLANES = XLEN / LANE_W;

`ifdef CUSTOM_EXT_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    cx_state_t        state;
    cx_state_t        state_d;
    cx_ctrl_t         ctrl_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [TAG_W-1:0] tag_q;

    logic             accept;
    logic             is_mul_req;
    logic             illegal_q;
    logic [XLEN-1:0]  fn_res;
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W:0]   lsum;

    logic             mul_busy;
    logic             mul_done;
    logic [XLEN-1:0]  mul_product;

    assign req_ready  = !flush && ((state == IDLE) || ((state == DONE) && resp_ready));
    assign accept     = req_valid && req_ready;
    assign is_mul_req = MUL_EN && (req_funct3 == CX_MUL) && (req_funct7 == CX_FUNCT7_LEGAL);
    assign illegal_q  = cx_illegal(ctrl_q, MUL_EN);

`ifdef CUSTOM_EXT_MUL_EN
    logic mul_start;
    assign mul_start = accept && is_mul_req;

    custom_ext_iter_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .start   (mul_start),
        .a       (req_a),
        .b       (req_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // State register and operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                ctrl_q <= '{funct7: req_funct7, funct3: req_funct3};
                a_q    <= req_a;
                b_q    <= req_b;
                tag_q  <= req_tag;
            end
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = is_mul_req ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d = DONE;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    if (accept) begin
                        state_d = is_mul_req ? BUSY : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Single-cycle function block on the captured operands; lanes never carry into each other.
    always_comb begin
        fn_res = '0;
        la     = '0;
        lb     = '0;
        lsum   = '0;
        case (ctrl_q.funct3)
            CX_XNOR: fn_res = a_q ^ ~b_q;
            CX_BREV: fn_res = {<<{a_q}};
            CX_VADD, CX_VSUB, CX_VADDU_SAT: begin
                for (int i = 0; i < int'(NLANES); i++) begin
                    la   = a_q[i*LANE_W +: LANE_W];
                    lb   = b_q[i*LANE_W +: LANE_W];
                    lsum = {1'b0, la} + {1'b0, lb};
                    if (ctrl_q.funct3 == CX_VADD) begin
                        fn_res[i*LANE_W +: LANE_W] = lsum[LANE_W-1:0];
                    end else if (ctrl_q.funct3 == CX_VSUB) begin
                        fn_res[i*LANE_W +: LANE_W] = la - lb;
                    end else begin
                        fn_res[i*LANE_W +: LANE_W] = lsum[LANE_W] ? '1 : lsum[LANE_W-1:0];
                    end
                end
            end
            default: fn_res = '0;
        endcase
    end

    // Response fields are held by the capture registers for as long as DONE lasts.
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) && illegal_q;
    assign resp_tag   = tag_q;
    assign resp_data  = ((state == DONE) && !illegal_q)
                      ? ((ctrl_q.funct3 == CX_MUL) ? mul_product : fn_res)
                      : '0;

endmodule

// File: tb/tb_custom_ext_seq_unit.sv
// Scoreboard bench for custom_ext_seq_unit: directed cases, randomized ops, backpressure, flush, reset.
module tb_custom_ext_seq_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned TAG_W  = 5;

`ifdef CUSTOM_EXT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    custom_ext_seq_unit #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [XLEN-1:0]  data;
        logic             err;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rr_mode = 2;   // 0 random, 1 hold low, 2 hold high

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: lane arithmetic done on plain integers, one lane at a time.
    function automatic exp_t model(input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        longint unsigned mask, modv, x, y, r, prod;
        e.tag  = tag;
        e.lat  = 1;
        e.err  = 1'b0;
        e.data = '0;
        e.acc  = 0;
        mask = (64'd1 << LANE_W) - 64'd1;
        modv = 64'd1 << LANE_W;
        if (f7 != 7'd0 || f3 > 3'd5 || (f3 == 3'd5 && !MUL_EN)) begin
            e.err = 1'b1;
        end else if (f3 == 3'd0) begin
            e.data = ~(a ^ b);
        end else if (f3 == 3'd4) begin
            for (int i = 0; i < int'(XLEN); i++) e.data[XLEN-1-i] = a[i];
        end else if (f3 == 3'd5) begin
            prod   = 64'(a) * 64'(b);
            e.data = prod[XLEN-1:0];
            e.lat  = XLEN + 1;
        end else begin
            for (int i = 0; i < int'(XLEN / LANE_W); i++) begin
                x = (64'(a) >> (i * LANE_W)) & mask;
                y = (64'(b) >> (i * LANE_W)) & mask;
                if (f3 == 3'd1)      r = (x + y) % modv;
                else if (f3 == 3'd2) r = (x + modv - y) % modv;
                else                 r = (x + y > mask) ? mask : x + y;
                e.data = e.data | XLEN'(r << (i * LANE_W));
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rr_mode == 0) resp_ready = ($urandom_range(0, 3) != 0);
        else              resp_ready = (rr_mode == 2);
    end

    // Monitor: pre-edge values at every rising edge; pops on handshake, pushes on accept.
    always @(posedge clk) begin
        if (rst_n) begin
            bit   ev;
            exp_t h;
            cyc++;
            ev = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
            chk("resp_valid", 64'(resp_valid), 64'(ev));
            if (ev) begin
                chk("resp_data", 64'(resp_data), 64'(q[0].data));
                chk("resp_tag",  64'(resp_tag),  64'(q[0].tag));
                chk("resp_err",  64'(resp_err),  64'(q[0].err));
            end
            chk("req_ready", 64'(req_ready),
                64'(!flush && (q.size() == 0 || (ev && resp_ready))));
            if (q.size() > 0 && cyc - q[0].acc > 200) begin
                chk("resp_timeout", 64'(0), 64'(1));
                q.delete();
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ev && resp_ready) void'(q.pop_front());
                if (req_valid && req_ready) begin
                    h     = model(req_funct3, req_funct7, req_a, req_b, req_tag);
                    h.acc = cyc;
                    q.push_back(h);
                end
            end
        end
    end

    // Present a request until accepted; returns the number of edges it waited.
    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag, output int n);
        bit got;
        n = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_funct7 = f7;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        do begin
            @(posedge clk);
            got = req_ready;
            n++;
        end while (!got && n < 300);
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
        #1;
        req_valid  = 1'b0;
        req_a      = $urandom;
        req_b      = $urandom;
        req_funct3 = 3'($urandom);
        req_tag    = TAG_W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        rr_mode = 2;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_req_ready"},  64'(req_ready),  64'(1));
        chk({tagname, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tagname, "_resp_data"},  64'(resp_data),  64'(0));
        chk({tagname, "_resp_tag"},   64'(resp_tag),   64'(0));
        chk({tagname, "_resp_err"},   64'(resp_err),   64'(0));
    endtask

    initial begin
        int n;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [XLEN-1:0] a, b;
        rst_n      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        issue(3'b001, 7'h00, 32'h0001_FFFF, 32'h0001_0001, 5'd1, n);
        issue(3'b010, 7'h00, 32'h0000_0000, 32'h0001_0001, 5'd2, n);
        issue(3'b011, 7'h00, 32'hF010_FF01, 32'h2010_0101, 5'd3, n);
        issue(3'b011, 7'h00, 32'hFFFF_8000, 32'h0001_8000, 5'd4, n);
        issue(3'b000, 7'h01, 32'h1234_5678, 32'h0, 5'd5, n);
        issue(3'b000, 7'h00, 32'h0, 32'h0, 5'd6, n);
        issue(3'b101, 7'h00, 32'd12345, 32'd6789, 5'd7, n);
        issue(3'b110, 7'h00, 32'hDEAD_BEEF, 32'h1, 5'd8, n);
        issue(3'b101, 7'h40, 32'd3, 32'd5, 5'd9, n);
        drain();

        // Backpressure on BREV, then a release cycle that also accepts the next request.
        rr_mode = 1;
        issue(3'b100, 7'h00, 32'h0000_0001, 32'hFFFF_FFFF, 5'd10, n);
        rr_mode = 1;
        repeat (5) @(posedge clk);
        #1 rr_mode = 2;
        issue(3'b000, 7'h00, 32'hA5A5_0000, 32'h0F0F_FFFF, 5'd11, n);
        chk("same_cycle_accept", 64'(n), 64'(1));
        drain();

        // Flush ten cycles into a MUL: nothing may come back for it.
        rr_mode = 1;
        issue(3'b101, 7'h00, 32'hFFFF_FFFF, 32'h1234_5678, 5'd12, n);
        repeat (9) @(posedge clk);
        pulse_flush();
        repeat (40) @(posedge clk);
        issue(3'b001, 7'h00, 32'h7FFF_7FFF, 32'h0001_0001, 5'd13, n);
        drain();

        // Async reset mid-MUL.
        issue(3'b101, 7'h00, 32'h0000_FFFF, 32'h0000_FFFF, 5'd14, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midmul_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b101, 7'h00, 32'h0001_0003, 32'h0000_0011, 5'd15, n);
        drain();

        // Randomized traffic with random backpressure and occasional flushes.
        rr_mode = 0;
        for (int i = 0; i < 300; i++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'h00;
            case ($urandom_range(0, 3))
                0:       a = '1;
                1:       a = 32'h8000_8000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h0001_0001 : $urandom;
            issue(f3, f7, a, b, TAG_W'($urandom), n);
            if ($urandom_range(0, 40) == 0) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                pulse_flush();
            end else if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
